croc_aging_sequencer: RTL and testbench
=======================================

# croc_aging_sequencer

Automated run controller for the FPGA aging campaign, sitting directly upstream of the croc SoC on the FPGA top and replacing manual VIO control of reset, fetch enable and GPIO inputs. It repeatedly resets the SoC, enables fetch, waits for the program's end-of-test status or a timeout, and checks a GPIO signature. It accumulates pass, fail and timeout counts plus the last run's latency, and exposes them for readback through VIO or UART.

## Interface
- ResetCycles, 64: cycles the SoC reset is held low in RST (≥1)
- TimeoutCycles, 32'd16_000_000: maximum RUN cycles before a run is declared timed out (≥2)
- GpioCount, 4: SoC GPIO width
- CntWidth, 32: width of the latency counter
- clk_i  in  1  SoC clock (soc_clk domain); every port is synchronous to it
- rst_i  in  1  synchronous, active-high reset
- start_i  in  1  starts a campaign when high in IDLE
- stop_i  in  1  requests a stop after the current run completes
- num_runs_i  in  16  runs per campaign, sampled at start; 0 means run until stopped
- expected_gpio_i  in  GpioCount  expected pass signature
- soc_rst_no  out  1  to the SoC rst_ni
- soc_fetch_en_o  out  1  to the SoC fetch_en_i
- soc_gpio_o  out  GpioCount  to the SoC gpio_i; per-run seed
- soc_status_i  in  1  from the SoC status_o
- soc_gpio_i  in  GpioCount  from the SoC gpio_o; result signature
- busy_o  out  1  campaign in progress
- done_o  out  1  one-cycle pulse when a campaign ends
- run_cnt_o, pass_cnt_o, fail_cnt_o, timeout_cnt_o  out  16 each  campaign counters
- last_cycles_o  out  CntWidth  RUN cycles of the last run
- last_gpio_o  out  GpioCount  signature captured in the last run

## Operation
- States: IDLE, RST, RUN, EVAL. Every output is registered.
- Reset values (rst_i high at a clock edge): state IDLE, soc_rst_no=0, soc_fetch_en_o=0, soc_gpio_o=0, busy_o=0, done_o=0, all counters 0, last_cycles_o=0, last_gpio_o=0, stop request cleared.
- IDLE:
  - SoC is held in reset with fetch disabled.
  - When start_i=1: latch num_runs_i, clear all four campaign counters and last_*, clear the stop request, set busy_o=1, go to RST.
- RST:
  - soc_rst_no=0, soc_fetch_en_o=0, soc_gpio_o = run_cnt_o[GpioCount-1:0].
  - Stays exactly ResetCycles cycles, then goes to RUN.
- RUN:
  - soc_rst_no=1 and soc_fetch_en_o=1, both asserted on the same cycle.
  - The cycle counter is cleared on entry and increments each RUN cycle; the first RUN cycle counts as 0.
  - If soc_status_i=1: last_cycles_o←counter, last_gpio_o←soc_gpio_i, then pass_cnt++ if soc_gpio_i==expected_gpio_i, otherwise fail_cnt++.
  - Else if counter==TimeoutCycles-1: timeout_cnt++, last_cycles_o←TimeoutCycles, last_gpio_o←soc_gpio_i.
  - In both exits run_cnt++ and the next state is EVAL.
  - Status and timeout on the same cycle: status wins.
- EVAL (one cycle):
  - soc_rst_no=0 and soc_fetch_en_o=0.
  - If the stop request is set, or num_runs≠0 and run_cnt_o==num_runs: go to IDLE, pulse done_o, and clear busy_o on the same edge.
  - Otherwise go to RST.
- stop_i is sticky while busy and is ignored in IDLE.
- start_i while busy is ignored.
- All 16-bit counters saturate at 16'hFFFF. The run-limit comparison uses the saturated value, so num_runs=65535 ends normally.
- rst_i asserted mid-run: the next state is IDLE with all reset values and no done_o pulse.

## Timing
- start_i high at edge N:
  - busy_o=1 from N+1.
  - soc_rst_no=0 for cycles N+1 … N+ResetCycles.
  - soc_rst_no=1 and soc_fetch_en_o=1 from N+ResetCycles+1.
- Status seen at the k-th RUN cycle (index k): the counters update one edge later, and soc_rst_no=0 in the following cycle (EVAL).
- Between runs, the SoC reset is low for ResetCycles+1 cycles (EVAL plus RST).
- A timed-out run lasts exactly TimeoutCycles RUN cycles.
- done_o is high for exactly one cycle, coincident with busy_o falling to 0 and the state entering IDLE.
- soc_gpio_o changes only on entry to RST and is stable throughout RUN.

## Test plan
- Use ResetCycles=4, TimeoutCycles=100, num_runs=3, expected=4'hA. SoC model asserts status 20 cycles after fetch_en with gpio=4'hA.
  - Required: pass=3, fail=0, timeout=0, run_cnt=3, last_cycles=20, one done_o pulse.
  - Required: soc_gpio_o sequence 0, 1, 2.
- Same setup but the model returns 4'h5 on the second run → pass=2, fail=1, last_gpio=4'hA.
- Model never asserts status, num_runs=2 → timeout=2, last_cycles=100, each RUN lasts exactly 100 cycles, done_o pulses.
- Model asserts status exactly on RUN cycle 99 → counted as pass or fail, timeout_cnt unchanged.
- num_runs=0, stop_i pulsed during the 5th run → campaign ends after the 5th run, run_cnt=5, start_i ignored while busy.
- rst_i asserted mid-RUN → next cycle soc_rst_no=0, all counters 0, busy_o=0, no done_o pulse; a following start_i runs normally.

Source files
------------

// File: rtl/croc_aging_sequencer.sv
// croc_aging_sequencer
// Automated run controller for the croc SoC aging campaign. It repeatedly
// holds the SoC in reset, releases it with fetch enabled, waits for the
// end-of-test status or a timeout, and grades the GPIO signature. Pass, fail
// and timeout tallies plus the latency and signature of the last run are
// kept for readback.

module croc_aging_sequencer #(
  parameter int unsigned ResetCycles   = 64,
  parameter logic [31:0] TimeoutCycles = 32'd16_000_000,
  parameter int unsigned GpioCount     = 4,
  parameter int unsigned CntWidth      = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic [15:0]          num_runs_i,
  input  logic [GpioCount-1:0] expected_gpio_i,
  output logic                 soc_rst_no,
  output logic                 soc_fetch_en_o,
  output logic [GpioCount-1:0] soc_gpio_o,
  input  logic                 soc_status_i,
  input  logic [GpioCount-1:0] soc_gpio_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [15:0]          run_cnt_o,
  output logic [15:0]          pass_cnt_o,
  output logic [15:0]          fail_cnt_o,
  output logic [15:0]          timeout_cnt_o,
  output logic [CntWidth-1:0]  last_cycles_o,
  output logic [GpioCount-1:0] last_gpio_o
);

  typedef enum logic [1:0] {
    StIdle,
    StRst,
    StRun,
    StEval
  } state_e;

  // The reset-hold counter only has to reach ResetCycles-1.
  localparam int unsigned RstCntW = (ResetCycles > 1) ? $clog2(ResetCycles) : 1;
  localparam logic [RstCntW-1:0]  RstLast    = RstCntW'(ResetCycles - 1);
  // The RUN cycle counter starts at 0, so the last allowed index is one less
  // than the timeout; a timed-out run reports the full timeout as its latency.
  localparam logic [CntWidth-1:0] RunLast    = CntWidth'(TimeoutCycles - 32'd1);
  localparam logic [CntWidth-1:0] TimeoutVal = CntWidth'(TimeoutCycles);

  state_e               state_q;
  logic [RstCntW-1:0]   rst_cnt_q;
  logic [CntWidth-1:0]  cyc_cnt_q;
  logic [15:0]          num_runs_q;
  logic                 stop_req_q;

  logic                 gpio_match;
  logic                 run_timeout;
  logic                 run_limit_hit;

  // Counters stick at all-ones instead of wrapping so long campaigns never
  // report misleadingly small numbers.
  function automatic logic [15:0] sat_inc(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

  assign gpio_match    = (soc_gpio_i == expected_gpio_i);
  assign run_timeout   = (cyc_cnt_q == RunLast);
  // A zero run count means run until stopped. The comparison uses the
  // saturated run counter so a limit of 65535 still terminates.
  assign run_limit_hit = (num_runs_q != 16'd0) && (run_cnt_o == num_runs_q);

  // Campaign sequencer: drives the SoC control pins, keeps the tallies and
  // decides after every run whether to continue or finish.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= StIdle;
      rst_cnt_q      <= '0;
      cyc_cnt_q      <= '0;
      num_runs_q     <= 16'd0;
      stop_req_q     <= 1'b0;
      soc_rst_no     <= 1'b0;
      soc_fetch_en_o <= 1'b0;
      soc_gpio_o     <= '0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      run_cnt_o      <= 16'd0;
      pass_cnt_o     <= 16'd0;
      fail_cnt_o     <= 16'd0;
      timeout_cnt_o  <= 16'd0;
      last_cycles_o  <= '0;
      last_gpio_o    <= '0;
    end else begin
      done_o <= 1'b0;

      // A stop request is remembered for the rest of the campaign and only
      // takes effect once the current run has been graded.
      if (busy_o && stop_i) begin
        stop_req_q <= 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          soc_rst_no     <= 1'b0;
          soc_fetch_en_o <= 1'b0;
          if (start_i) begin
            num_runs_q    <= num_runs_i;
            run_cnt_o     <= 16'd0;
            pass_cnt_o    <= 16'd0;
            fail_cnt_o    <= 16'd0;
            timeout_cnt_o <= 16'd0;
            last_cycles_o <= '0;
            last_gpio_o   <= '0;
            stop_req_q    <= 1'b0;
            busy_o        <= 1'b1;
            rst_cnt_q     <= '0;
            soc_gpio_o    <= '0;
            state_q       <= StRst;
          end
        end

        StRst: begin
          if (rst_cnt_q == RstLast) begin
            soc_rst_no     <= 1'b1;
            soc_fetch_en_o <= 1'b1;
            cyc_cnt_q      <= '0;
            state_q        <= StRun;
          end else begin
            rst_cnt_q <= rst_cnt_q + 1'b1;
          end
        end

        StRun: begin
          if (soc_status_i) begin
            last_cycles_o <= cyc_cnt_q;
            last_gpio_o   <= soc_gpio_i;
            if (gpio_match) begin
              pass_cnt_o <= sat_inc(pass_cnt_o);
            end else begin
              fail_cnt_o <= sat_inc(fail_cnt_o);
            end
            run_cnt_o      <= sat_inc(run_cnt_o);
            soc_rst_no     <= 1'b0;
            soc_fetch_en_o <= 1'b0;
            state_q        <= StEval;
          end else if (run_timeout) begin
            last_cycles_o  <= TimeoutVal;
            last_gpio_o    <= soc_gpio_i;
            timeout_cnt_o  <= sat_inc(timeout_cnt_o);
            run_cnt_o      <= sat_inc(run_cnt_o);
            soc_rst_no     <= 1'b0;
            soc_fetch_en_o <= 1'b0;
            state_q        <= StEval;
          end else begin
            cyc_cnt_q <= cyc_cnt_q + 1'b1;
          end
        end

        StEval: begin
          if (stop_req_q || run_limit_hit) begin
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
            state_q <= StIdle;
          end else begin
            // The low bits of the completed-run count seed the next run.
            soc_gpio_o <= GpioCount'(run_cnt_o);
            rst_cnt_q  <= '0;
            state_q    <= StRst;
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_croc_aging_sequencer.sv
// tb_croc_aging_sequencer
// Self-checking bench: a timeline-based reference model predicts every
// output on every cycle, a small SoC model answers fetch enable with a
// planned status delay and signature, and directed plus random campaigns
// exercise pass, fail, timeout, stop, ignored start and mid-run reset.

module tb_croc_aging_sequencer;

  localparam int unsigned RC    = 4;
  localparam logic [31:0] TO    = 32'd100;
  localparam int unsigned GW    = 4;
  localparam int unsigned CW    = 32;
  localparam int          NEVER = 100000;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic          stop_i;
  logic [15:0]   num_runs_i;
  logic [GW-1:0] expected_gpio_i;
  logic          soc_rst_no;
  logic          soc_fetch_en_o;
  logic [GW-1:0] soc_gpio_o;
  logic          soc_status_i = 1'b0;
  logic [GW-1:0] soc_gpio_i = '0;
  logic          busy_o;
  logic          done_o;
  logic [15:0]   run_cnt_o;
  logic [15:0]   pass_cnt_o;
  logic [15:0]   fail_cnt_o;
  logic [15:0]   timeout_cnt_o;
  logic [CW-1:0] last_cycles_o;
  logic [GW-1:0] last_gpio_o;

  croc_aging_sequencer #(
    .ResetCycles  (RC),
    .TimeoutCycles(TO),
    .GpioCount    (GW),
    .CntWidth     (CW)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .stop_i         (stop_i),
    .num_runs_i     (num_runs_i),
    .expected_gpio_i(expected_gpio_i),
    .soc_rst_no     (soc_rst_no),
    .soc_fetch_en_o (soc_fetch_en_o),
    .soc_gpio_o     (soc_gpio_o),
    .soc_status_i   (soc_status_i),
    .soc_gpio_i     (soc_gpio_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .run_cnt_o      (run_cnt_o),
    .pass_cnt_o     (pass_cnt_o),
    .fail_cnt_o     (fail_cnt_o),
    .timeout_cnt_o  (timeout_cnt_o),
    .last_cycles_o  (last_cycles_o),
    .last_gpio_o    (last_gpio_o)
  );

  // Free-running SoC clock.
  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Per-run plan for the SoC model: status delay (RUN index) and signature.
  int            plan_delay [16];
  logic [GW-1:0] plan_gpio  [16];

  // Reference model state, expressed as a timeline of cycle numbers.
  int            cyc         = 0;
  bit            m_busy      = 1'b0;
  bit            m_done      = 1'b0;
  bit            m_stop      = 1'b0;
  int            m_target    = 0;
  int            m_run       = 0;
  int            m_pass      = 0;
  int            m_fail      = 0;
  int            m_to        = 0;
  int            m_last_cyc  = 0;
  logic [GW-1:0] m_last_gpio = '0;
  logic [GW-1:0] m_seed      = '0;
  bit            run_active  = 1'b0;
  int            run_begin   = 0;
  int            eval_at     = -1;
  bit            exp_run;
  bit            busy_now;
  bit            end_run;
  int            k_m;
  int            idx_m;

  // Observations taken from the DUT pins.
  int            done_seen  = 0;
  bit            prev_fetch = 1'b0;
  int            fetch_len  = 0;
  logic [GW-1:0] seeds    [$];
  int            run_lens [$];

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  // Compare, SoC response and model step, all on the falling edge.
  always @(negedge clk_i) begin
    cyc++;
    exp_run = run_active && (cyc >= run_begin);

    if (chk_en) begin
      checkOutput("soc_rst_no",     soc_rst_no,     exp_run);
      checkOutput("soc_fetch_en_o", soc_fetch_en_o, exp_run);
      checkOutput("soc_gpio_o",     soc_gpio_o,     m_seed);
      checkOutput("busy_o",         busy_o,         m_busy);
      checkOutput("done_o",         done_o,         m_done);
      checkOutput("run_cnt_o",      run_cnt_o,      m_run);
      checkOutput("pass_cnt_o",     pass_cnt_o,     m_pass);
      checkOutput("fail_cnt_o",     fail_cnt_o,     m_fail);
      checkOutput("timeout_cnt_o",  timeout_cnt_o,  m_to);
      checkOutput("last_cycles_o",  last_cycles_o,  m_last_cyc);
      checkOutput("last_gpio_o",    last_gpio_o,    m_last_gpio);
    end

    if (done_o === 1'b1) done_seen++;
    if (soc_fetch_en_o === 1'b1) begin
      if (!prev_fetch) begin
        seeds.push_back(soc_gpio_o);
        fetch_len = 0;
      end
      fetch_len++;
    end else if (prev_fetch) begin
      run_lens.push_back(fetch_len);
    end
    prev_fetch = (soc_fetch_en_o === 1'b1);

    idx_m = (m_run < 16) ? m_run : 15;
    if (exp_run && ((cyc - run_begin) == plan_delay[idx_m])) begin
      soc_status_i = 1'b1;
      soc_gpio_i   = plan_gpio[idx_m];
    end else begin
      soc_status_i = 1'b0;
      soc_gpio_i   = GW'($urandom);
    end

    m_done   = 1'b0;
    busy_now = m_busy;
    if (rst_i) begin
      m_busy = 0; m_stop = 0; m_target = 0; m_run = 0; m_pass = 0; m_fail = 0;
      m_to = 0; m_last_cyc = 0; m_last_gpio = '0; m_seed = '0;
      run_active = 0; eval_at = -1;
    end else if (!m_busy) begin
      if (start_i) begin
        m_busy = 1; m_stop = 0; m_target = num_runs_i; m_run = 0; m_pass = 0;
        m_fail = 0; m_to = 0; m_last_cyc = 0; m_last_gpio = '0; m_seed = '0;
        run_active = 1; run_begin = cyc + RC + 1;
      end
    end else begin
      if (eval_at == cyc) begin
        eval_at = -1;
        if (m_stop || (m_target != 0 && m_run == m_target)) begin
          m_busy = 0;
          m_done = 1;
        end else begin
          m_seed     = GW'(m_run);
          run_active = 1;
          run_begin  = cyc + RC + 1;
        end
      end else if (exp_run) begin
        k_m     = cyc - run_begin;
        end_run = 1'b0;
        if (soc_status_i) begin
          m_last_cyc  = k_m;
          m_last_gpio = soc_gpio_i;
          if (soc_gpio_i == expected_gpio_i) m_pass = sat16(m_pass + 1);
          else m_fail = sat16(m_fail + 1);
          end_run = 1'b1;
        end else if (k_m == int'(TO) - 1) begin
          m_to        = sat16(m_to + 1);
          m_last_cyc  = int'(TO);
          m_last_gpio = soc_gpio_i;
          end_run     = 1'b1;
        end
        if (end_run) begin
          m_run      = sat16(m_run + 1);
          run_active = 0;
          eval_at    = cyc + 1;
        end
      end
      if (busy_now && stop_i) m_stop = 1;
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic setPlan(input int delay, input logic [GW-1:0] gpio);
    for (int i = 0; i < 16; i++) begin
      plan_delay[i] = delay;
      plan_gpio[i]  = gpio;
    end
  endtask

  task automatic applyStimulus(input int runs, input logic [GW-1:0] exp_g);
    seeds.delete();
    run_lens.delete();
    tick();
    num_runs_i      = 16'(runs);
    expected_gpio_i = exp_g;
    start_i         = 1'b1;
    tick();
    start_i    = 1'b0;
    num_runs_i = 16'($urandom);
    checkOutput("busy_after_start", busy_o, 1);
  endtask

  task automatic waitDone(input int d0);
    int waited = 0;
    while (done_seen == d0 && waited < 20000) begin
      tick();
      waited++;
    end
    if (done_seen == d0) checkOutput("campaign_done_in_time", 0, 1);
    tick();
  endtask

  task automatic waitRunFetch(input int run_idx);
    int waited = 0;
    while (!(run_cnt_o == 16'(run_idx) && soc_fetch_en_o === 1'b1) && waited < 5000) begin
      tick();
      waited++;
    end
    if (waited >= 5000) checkOutput("reached_run", run_idx, run_idx + 1);
  endtask

  // Directed and random campaigns with hand-computed end-of-campaign checks.
  initial begin
    int d0;
    int runs;
    logic [GW-1:0] eg;
    rst_i = 1'b1; start_i = 1'b0; stop_i = 1'b0;
    num_runs_i = 16'd0; expected_gpio_i = 4'hA;
    setPlan(NEVER, 4'h0);
    repeat (3) @(posedge clk_i);
    #2;
    rst_i  = 1'b0;
    chk_en = 1'b1;
    checkOutput("reset_soc_rst_no", soc_rst_no, 0);
    checkOutput("reset_fetch_en", soc_fetch_en_o, 0);
    checkOutput("reset_busy", busy_o, 0);
    checkOutput("reset_run_cnt", run_cnt_o, 0);
    checkOutput("reset_last_cycles", last_cycles_o, 0);
    checkOutput("reset_soc_gpio", soc_gpio_o, 0);

    // Three passing runs, status 20 cycles after fetch enable.
    setPlan(20, 4'hA);
    d0 = done_seen;
    applyStimulus(3, 4'hA);
    waitDone(d0);
    checkOutput("A_pass", pass_cnt_o, 3);
    checkOutput("A_fail", fail_cnt_o, 0);
    checkOutput("A_timeout", timeout_cnt_o, 0);
    checkOutput("A_run_cnt", run_cnt_o, 3);
    checkOutput("A_last_cycles", last_cycles_o, 20);
    checkOutput("A_done_pulses", done_seen - d0, 1);
    checkOutput("A_seed_count", seeds.size(), 3);
    for (int i = 0; i < 3 && i < seeds.size(); i++) checkOutput("A_seed", seeds[i], i);
    for (int i = 0; i < run_lens.size(); i++) checkOutput("A_run_len", run_lens[i], 21);

    // Stop is ignored while idle; second run returns a bad signature.
    tick(); stop_i = 1'b1; tick(); stop_i = 1'b0;
    setPlan(20, 4'hA);
    plan_gpio[1] = 4'h5;
    d0 = done_seen;
    applyStimulus(3, 4'hA);
    waitDone(d0);
    checkOutput("B_pass", pass_cnt_o, 2);
    checkOutput("B_fail", fail_cnt_o, 1);
    checkOutput("B_last_gpio", last_gpio_o, 4'hA);
    checkOutput("B_run_cnt", run_cnt_o, 3);

    // SoC never reports: two timeouts of exactly TO RUN cycles.
    setPlan(NEVER, 4'h0);
    d0 = done_seen;
    applyStimulus(2, 4'hA);
    waitDone(d0);
    checkOutput("C_timeout", timeout_cnt_o, 2);
    checkOutput("C_last_cycles", last_cycles_o, 100);
    checkOutput("C_done_pulses", done_seen - d0, 1);
    checkOutput("C_run_len_count", run_lens.size(), 2);
    for (int i = 0; i < run_lens.size(); i++) checkOutput("C_run_len", run_lens[i], 100);

    // Status on the very last RUN cycle beats the timeout.
    setPlan(99, 4'h3);
    d0 = done_seen;
    applyStimulus(1, 4'h3);
    waitDone(d0);
    checkOutput("D_pass", pass_cnt_o, 1);
    checkOutput("D_timeout", timeout_cnt_o, 0);
    checkOutput("D_last_cycles", last_cycles_o, 99);

    // Unlimited campaign, start ignored while busy, stop during the 5th run.
    setPlan(8, 4'h6);
    d0 = done_seen;
    applyStimulus(0, 4'h6);
    waitRunFetch(1);
    num_runs_i = 16'd2; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    waitRunFetch(4);
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    waitDone(d0);
    checkOutput("E_run_cnt", run_cnt_o, 5);
    checkOutput("E_pass", pass_cnt_o, 5);
    checkOutput("E_done_pulses", done_seen - d0, 1);

    // Random campaigns mixing passes, fails and timeouts.
    for (int c = 0; c < 4; c++) begin
      runs = $urandom_range(1, 4);
      eg   = GW'($urandom);
      for (int i = 0; i < 16; i++) begin
        plan_delay[i] = $urandom_range(0, 120);
        plan_gpio[i]  = ($urandom_range(0, 1) == 1) ? eg : GW'($urandom);
      end
      d0 = done_seen;
      applyStimulus(runs, eg);
      waitDone(d0);
      checkOutput("R_run_cnt", run_cnt_o, runs);
      checkOutput("R_tally_sum", pass_cnt_o + fail_cnt_o + timeout_cnt_o, runs);
    end

    // Reset in the middle of a run, then a normal campaign.
    setPlan(50, 4'hA);
    applyStimulus(3, 4'hA);
    waitRunFetch(1);
    repeat (10) tick();
    d0 = done_seen;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    checkOutput("X_soc_rst_no", soc_rst_no, 0);
    checkOutput("X_fetch_en", soc_fetch_en_o, 0);
    checkOutput("X_busy", busy_o, 0);
    checkOutput("X_run_cnt", run_cnt_o, 0);
    checkOutput("X_pass", pass_cnt_o, 0);
    repeat (5) tick();
    checkOutput("X_no_done", done_seen - d0, 0);
    setPlan(7, 4'hC);
    d0 = done_seen;
    applyStimulus(1, 4'hC);
    waitDone(d0);
    checkOutput("Y_pass", pass_cnt_o, 1);
    checkOutput("Y_last_cycles", last_cycles_o, 7);

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
